// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Picks SYNC/LEN/PAYLOAD/CHK frames out of the UART receiver byte stream.
// It verifies the XOR checksum and replays good payloads as a valid/ready
// stream with a last marker. Rejected frames raise frame_err with a reason code.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] drop_cnt
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  // Saturating increment for the 8-bit drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // True when a LEN byte is a usable payload length.
  function automatic logic len_ok(input logic [7:0] v);
    return (v != 8'd0) && (32'(v) <= 32'(MAX_LEN));
  endfunction

  state_t           state_q, state_d;
  logic             rx_valid_q, rx_valid_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [7:0]       chk_q, chk_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             byte_stb;
  logic             pay_we;
  logic [7:0]       pay_mem [MAX_LEN];

  // One strobe per rising edge of rx_valid, so level-held valid counts once.
  assign byte_stb = rx_valid & ~rx_valid_q;

  // Next-state, checksum, timeout and status pulse generation.
  always_comb begin
    state_d     = state_q;
    rx_valid_d  = rx_valid;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    chk_d       = chk_q;
    tmo_d       = '0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    drop_cnt_d  = drop_cnt_q;
    pay_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (byte_stb && (rx_data == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end

      S_LEN, S_PAYLOAD, S_CHECK: begin
        if (byte_stb) begin
          // A byte arriving on the expiry cycle wins over the timeout.
          tmo_d = '0;
          if (state_q == S_LEN) begin
            if (len_ok(rx_data)) begin
              len_d   = rx_data[IDX_W-1:0];
              chk_d   = rx_data;
              idx_d   = '0;
              state_d = S_PAYLOAD;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_LEN;
              state_d     = S_IDLE;
            end
          end else if (state_q == S_PAYLOAD) begin
            pay_we = 1'b1;
            chk_d  = chk_q ^ rx_data;
            idx_d  = idx_q + IDX_ONE;
            if (idx_q == len_q - IDX_ONE) begin
              state_d = S_CHECK;
            end
          end else begin
            if (rx_data == chk_q) begin
              frame_ok_d = 1'b1;
              rd_d       = '0;
              state_d    = S_DRAIN;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_CHK;
              state_d     = S_IDLE;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TMO;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DRAIN: begin
        // Bytes arriving while the payload is still being replayed are lost.
        if (byte_stb) begin
          drop_cnt_d = sat_inc8(drop_cnt_q);
        end
        if (out_ready) begin
          if (rd_q == len_q - IDX_ONE) begin
            state_d = S_IDLE;
          end else begin
            rd_d = rd_q + IDX_ONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rx_valid_q  <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Payload buffer; contents are only read in DRAIN, so no reset is needed.
  always_ff @(posedge clk) begin
    if (pay_we) begin
      pay_mem[idx_q[ADDR_W-1:0]] <= rx_data;
    end
  end

  // Output stream is gated by DRAIN so every output reads 0 outside it.
  always_comb begin
    out_valid = (state_q == S_DRAIN);
    out_data  = out_valid ? pay_mem[rd_q[ADDR_W-1:0]] : 8'd0;
    out_last  = out_valid && (rd_q == len_q - IDX_ONE);
  end

  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: stimulus pushes expected events,
// a negedge monitor pops and compares frame_ok/frame_err/payload beats.
module tb_uart_frame_parser;

  localparam int TMO = 64;

  localparam logic [1:0] K_OK   = 2'd0;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_BYTE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic [1:0] aux;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] drop_cnt;

  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];

  uart_frame_parser #(
    .SYNC_BYTE      (8'hA5),
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_ev(input ev_t act);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d data=%0h aux=%0h expected none",
               act.kind, act.data, act.aux);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_bad++;
        $display("FAIL event: got kind=%0d data=%0h aux=%0h expected kind=%0d data=%0h aux=%0h",
                 act.kind, act.data, act.aux, e.kind, e.data, e.aux);
      end
    end
  endtask

  // Monitor: checks every DUT-side event against the scoreboard queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (frame_ok) compare_ev('{K_OK, 8'h00, 2'b00});
      if (frame_err) compare_ev('{K_ERR, 8'h00, err_code});
      if (out_valid && out_ready) compare_ev('{K_BYTE, out_data, {1'b0, out_last}});
    end
  end

  task automatic push_ok();
    exp_q.push_back('{K_OK, 8'h00, 2'b00});
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_q.push_back('{K_ERR, 8'h00, code});
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    exp_q.push_back('{K_BYTE, d, {1'b0, last}});
  endtask

  // Present one byte with rx_valid held for 'hold' cycles, then a gap.
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk({"drain_", name}, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({out_data, out_valid, out_last, frame_ok, frame_err, err_code, drop_cnt});
  endfunction

  logic       stable;
  logic [7:0] held_data;

  initial begin
    reset_n   = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("outs_in_reset", all_outs(), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("outs_after_reset", all_outs(), 32'd0);

    // 1: good 3-byte frame
    push_ok(); push_byte(8'h11, 1'b0); push_byte(8'h22, 1'b0); push_byte(8'h33, 1'b1);
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
    send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h03, 1);
    wait_drain("good3", 50);

    // 2: bad checksum
    push_err(2'b10);
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
    send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h00, 1);
    wait_drain("badchk", 50);
    chk("err_code_hold_chk", 32'(err_code), 32'd2);

    // 3: zero length and over-long length
    push_err(2'b01);
    send_byte(8'hA5, 1); send_byte(8'h00, 1);
    push_err(2'b01);
    send_byte(8'hA5, 1); send_byte(8'h11, 1);
    wait_drain("badlen", 50);
    chk("err_code_hold_len", 32'(err_code), 32'd1);

    // 4: timeout mid-payload, then a clean frame
    push_err(2'b11);
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h7E, 1);
    wait_drain("timeout", TMO * 3);
    chk("err_code_hold_tmo", 32'(err_code), 32'd3);
    push_ok(); push_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h5A, 1); send_byte(8'h5B, 1);
    wait_drain("after_tmo", 50);

    // 5: stalled consumer while extra bytes arrive
    out_ready = 1'b0;
    push_ok(); push_byte(8'hC3, 1'b0); push_byte(8'h3C, 1'b1);
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'hC3, 1);
    send_byte(8'h3C, 1); send_byte(8'hFD, 1);
    @(negedge clk);
    stable    = out_valid;
    held_data = out_data;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (!out_valid || out_data !== held_data || out_last !== 1'b0) stable = 1'b0;
        end
      end
      begin
        send_byte(8'h01, 1); send_byte(8'hA5, 1); send_byte(8'h77, 1);
      end
    join
    chk("stall_stable", 32'(stable), 32'd1);
    chk("stall_data", 32'(held_data), 32'hC3);
    chk("drop_cnt", 32'(drop_cnt), 32'd3);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain("stall", 50);

    // 6: level-held valid, reset mid-payload, then a clean frame
    send_byte(8'hA5, 4); send_byte(8'h03, 4); send_byte(8'h10, 4); send_byte(8'h20, 4);
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    chk("outs_mid_reset", all_outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("outs_post_reset", all_outs(), 32'd0);
    push_ok(); push_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 4); send_byte(8'h01, 4); send_byte(8'h5A, 4); send_byte(8'h5B, 4);
    wait_drain("held_valid", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
